qpsk_symbol_mapper: RTL and testbench
=====================================

// Module: qpsk_symbol_mapper
// PURPOSE
//  Transmit-side QPSK mapper, the counterpart of the receive hard-decision slicer.
//  - Takes a serial bit stream through a valid/ready handshake and splits it into
//    pairs: the first bit goes to I, the second to Q.
//  - Maps each bit to a 2-bit bipolar level: bit 0 -> 2'b01 (+1), bit 1 -> 2'b11 (-1).
//  - Emits one symbol every SPS clk_fs cycles into the I/Q pulse-shaping filters.
//  - The receiver slices on the same SPS-cycle grid.
// PARAMETERS
//  SPS   4  clk_fs cycles per symbol; legal range 2..16
//  PH_W  4  phase counter width; must satisfy 2**PH_W >= SPS
// PORTS
//  clk_fs      in   1  sample clock, 10 MHz
//  rst_n       in   1  reset, asynchronous, active-low
//  en          in   1  transmit enable, sampled at symbol boundaries
//  bit_in      in   1  serial data bit
//  bit_valid   in   1  bit_in valid
//  bit_ready   out  1  mapper can accept bit_in
//  sym_out_I   out  2  I level to shaping filter: 01=+1, 11=-1, 00=zero
//  sym_out_Q   out  2  Q level to shaping filter, same coding as I
//  sym_strobe  out  1  high in the first output cycle of each symbol
//  underflow   out  1  1-cycle pulse: symbol boundary reached with no pair ready
//  busy        out  1  high while in the RUN state
// BEHAVIOUR
//  Reset values:
//  - sym_out_I/Q = 00, sym_strobe = 0, underflow = 0, busy = 0.
//  - State = IDLE, phase = 0, pair register cleared, half flag cleared, bit_ready = 1.
//  - A reset asserted mid-operation drops any partial or complete pair.
//  Bit collector:
//  - A handshake completes when bit_valid & bit_ready are both high at a clk_fs edge.
//  - bit_ready = ~pair_full.
//  - First accepted bit goes to I and sets half; second goes to Q, clears half, sets pair_full.
//  - The collector keeps accepting bits while en = 0.
//  - bit_valid held high while bit_ready = 0 loses no data.
//  Symbol timer and FSM (all outputs registered):
//  - IDLE: outputs 00, phase held at 0.
//    If en & pair_full: load the pair into the output register, clear pair_full,
//    assert sym_strobe, go to RUN with phase = 0.
//  - RUN: phase increments every cycle.
//    At phase == SPS-1 (symbol boundary):
//      en & pair_full -> load the next pair, strobe, phase wraps to 0, stay in RUN.
//      en & ~pair_full -> pulse underflow, outputs 00, go to IDLE.
//      ~en -> go to IDLE, no underflow pulse.
//  - Load and a new bit handshake never coincide, because bit_ready is 0 while pair_full.
//  Latency:
//  - Q bit handshake in cycle N, state IDLE: sym_strobe and the symbol appear in cycle N+2.
//  - Back-to-back symbols: strobes are exactly SPS cycles apart.
//  Output waveform (zero-stuffing, default):
//  - The mapped level is driven only in the strobe cycle.
//  - sym_out_I/Q = 00 in the other SPS-1 cycles of the symbol.
// CONFIGURATION
//  QPSK_MAP_HOLD_EN
//  - Defined: sample-and-hold (NRZ); the level is held for all SPS cycles of the symbol.
//    IDLE still outputs 00.
//  - Undefined: zero-stuffing as above.
//  - sym_strobe, underflow and the handshake are identical in both builds.
// TESTING
//  1. Reset with bit_valid = 0 -> outputs 00, sym_strobe = 0, bit_ready = 1, busy = 0.
//  2. en = 1; bits 0 then 1 in consecutive cycles (Q handshake in cycle N), SPS = 4
//     -> cycle N+2: I = 01, Q = 11, strobe = 1; next 3 cycles I/Q = 00.
//  3. Continuous stream 1,1,0,0,1,0 with bit_valid always high
//     -> symbols (11,11), (01,01), (11,01); strobes 4 cycles apart; underflow never asserts.
//  4. Feed exactly one pair, then stop
//     -> underflow pulses 1 cycle at the phase-3 boundary; then busy = 0, outputs 00.
//  5. Single bit 1 accepted, rst_n pulsed low mid-symbol, then bits 0,1
//     -> first symbol is I = 01, Q = 11; the pre-reset bit is discarded.
//  6. Build with QPSK_MAP_HOLD_EN, repeat test 2
//     -> I = 01, Q = 11 held for 4 cycles, then 00 after the underflow boundary.

Source files
------------

// File: rtl/qpsk_symbol_mapper.sv
// qpsk_symbol_mapper
//   Transmit-side QPSK mapper. Serial bits arrive over a valid/ready handshake
//   and are paired: the first bit of a pair drives I and the second drives Q.
//   Each bit maps to a bipolar 2-bit level: 0 -> 2'b01 (+1), 1 -> 2'b11 (-1).
//   One symbol is launched every SPS clk_fs cycles, on the same grid the
//   receive slicer uses.
//
//   Optional build macro QPSK_MAP_HOLD_EN:
//     defined   - sample-and-hold (NRZ): the level is held for all SPS cycles.
//     undefined - zero-stuffing: the level is driven only in the strobe cycle.
//   sym_strobe, underflow and the handshake behave identically in both builds.
//
//   Parameter constraints: 2 <= SPS <= 16, 2**PH_W >= SPS.

module qpsk_symbol_mapper #(
  parameter int SPS  = 4,
  parameter int PH_W = 4
) (
  input  logic       clk_fs,
  input  logic       rst_n,
  input  logic       en,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [1:0] sym_out_I,
  output logic [1:0] sym_out_Q,
  output logic       sym_strobe,
  output logic       underflow,
  output logic       busy
);

  // Symbol timer states: IDLE waits for a pair, RUN paces symbols.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0]      LVL_POS  = 2'b01;
  localparam logic [1:0]      LVL_NEG  = 2'b11;
  localparam logic [1:0]      LVL_ZERO = 2'b00;
  localparam logic [PH_W-1:0] PH_ZERO  = '0;
  localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(SPS - 1);

  // Bit-to-level mapping shared by the I and Q rails.
  function automatic logic [1:0] map_level(input logic b);
    logic [1:0] lvl;
    if (b) begin
      lvl = LVL_NEG;
    end else begin
      lvl = LVL_POS;
    end
    return lvl;
  endfunction

  // Collector state
  logic            pair_i_r;
  logic            pair_q_r;
  logic            half_r;
  logic            pair_full_r;

  // Timer / output state
  state_t          state_r;
  logic [PH_W-1:0] phase_r;
  logic [1:0]      sym_i_r;
  logic [1:0]      sym_q_r;
  logic            strobe_r;
  logic            underflow_r;
  logic            busy_r;

  // Handshake and timing decodes
  logic            accept_s;
  logic            boundary_s;
  logic            load_s;

  // Decode handshake, symbol boundary and pair load for the current cycle.
  always_comb begin
    accept_s   = 1'b0;
    boundary_s = 1'b0;
    load_s     = 1'b0;
    accept_s   = bit_valid & ~pair_full_r;
    if (state_r == ST_RUN) begin
      boundary_s = (phase_r == PH_LAST);
    end else begin
      boundary_s = 1'b0;
    end
    // A load happens in IDLE whenever a pair waits, or in RUN at the boundary.
    // pair_full blocks new handshakes, so a load never meets an accept.
    if ((state_r == ST_IDLE) || boundary_s) begin
      load_s = en & pair_full_r;
    end else begin
      load_s = 1'b0;
    end
  end

  // Bit collector: pack two accepted bits into the pair register.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      pair_i_r    <= 1'b0;
      pair_q_r    <= 1'b0;
      half_r      <= 1'b0;
      pair_full_r <= 1'b0;
    end else if (load_s) begin
      pair_full_r <= 1'b0;
    end else if (accept_s) begin
      if (!half_r) begin
        pair_i_r <= bit_in;
        half_r   <= 1'b1;
      end else begin
        pair_q_r    <= bit_in;
        half_r      <= 1'b0;
        pair_full_r <= 1'b1;
      end
    end else begin
      pair_full_r <= pair_full_r;
    end
  end

  // Symbol timer FSM with registered level, strobe, underflow and busy.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      phase_r     <= PH_ZERO;
      sym_i_r     <= LVL_ZERO;
      sym_q_r     <= LVL_ZERO;
      strobe_r    <= 1'b0;
      underflow_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      strobe_r    <= 1'b0;
      underflow_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          phase_r <= PH_ZERO;
          if (load_s) begin
            sym_i_r  <= map_level(pair_i_r);
            sym_q_r  <= map_level(pair_q_r);
            strobe_r <= 1'b1;
            state_r  <= ST_RUN;
            busy_r   <= 1'b1;
          end else begin
            sym_i_r <= LVL_ZERO;
            sym_q_r <= LVL_ZERO;
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (boundary_s) begin
            phase_r <= PH_ZERO;
            if (load_s) begin
              sym_i_r  <= map_level(pair_i_r);
              sym_q_r  <= map_level(pair_q_r);
              strobe_r <= 1'b1;
            end else begin
              // Either starved (en high) or disabled: drop back to IDLE,
              // flagging underflow only when more data was wanted.
              sym_i_r     <= LVL_ZERO;
              sym_q_r     <= LVL_ZERO;
              underflow_r <= en;
              state_r     <= ST_IDLE;
              busy_r      <= 1'b0;
            end
          end else begin
            phase_r <= phase_r + PH_ONE;
`ifdef QPSK_MAP_HOLD_EN
            sym_i_r <= sym_i_r;
            sym_q_r <= sym_q_r;
`else
            sym_i_r <= LVL_ZERO;
            sym_q_r <= LVL_ZERO;
`endif
          end
        end
        default: begin
          state_r <= ST_IDLE;
          phase_r <= PH_ZERO;
          sym_i_r <= LVL_ZERO;
          sym_q_r <= LVL_ZERO;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bit_ready  = ~pair_full_r;
  assign sym_out_I  = sym_i_r;
  assign sym_out_Q  = sym_q_r;
  assign sym_strobe = strobe_r;
  assign underflow  = underflow_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// tb_qpsk_symbol_mapper
//   Directed scenarios with literal expectations, followed by randomized
//   traffic compared every cycle against a queue-based reference model.
//   Honours QPSK_MAP_HOLD_EN the same way the design does.

module tb_qpsk_symbol_mapper;

  localparam int SPS  = 4;
  localparam int PH_W = 4;

  logic       clk_fs = 1'b0;
  logic       rst_n;
  logic       en;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [1:0] sym_out_I;
  logic [1:0] sym_out_Q;
  logic       sym_strobe;
  logic       underflow;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  qpsk_symbol_mapper #(.SPS(SPS), .PH_W(PH_W)) dut (
    .clk_fs     (clk_fs),
    .rst_n      (rst_n),
    .en         (en),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .sym_out_I  (sym_out_I),
    .sym_out_Q  (sym_out_Q),
    .sym_strobe (sym_strobe),
    .underflow  (underflow),
    .busy       (busy)
  );

  // 10 MHz sample clock
  always #50 clk_fs = ~clk_fs;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] lvl(input bit b);
    return b ? 2'b11 : 2'b01;
  endfunction

  // Reference model: accepted bits sit in a queue; a symbol slot is SPS cycles.
  bit         mq[$];
  bit         m_run;
  int         m_cnt;
  logic [1:0] m_i, m_q;
  logic       m_stb, m_uf;

  initial begin : model
    bit hs;
    mq.delete();
    m_run = 0; m_cnt = 0; m_i = 2'b00; m_q = 2'b00; m_stb = 1'b0; m_uf = 1'b0;
    forever begin
      @(posedge clk_fs or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_run = 0; m_cnt = 0; m_i = 2'b00; m_q = 2'b00; m_stb = 1'b0; m_uf = 1'b0;
      end else begin
        hs = bit_valid && (mq.size() < 2);
        m_stb = 1'b0;
        m_uf  = 1'b0;
        if (!m_run || m_cnt == SPS - 1) begin
          if (en && mq.size() == 2) begin
            m_i = lvl(mq[0]);
            m_q = lvl(mq[1]);
            mq.delete();
            m_stb = 1'b1; m_run = 1; m_cnt = 0;
          end else begin
            if (m_run && en) m_uf = 1'b1;
            m_run = 0; m_cnt = 0; m_i = 2'b00; m_q = 2'b00;
          end
        end else begin
          m_cnt++;
`ifndef QPSK_MAP_HOLD_EN
          m_i = 2'b00; m_q = 2'b00;
`endif
        end
        if (hs) mq.push_back(bit_in);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin : compare
    forever begin
      @(negedge clk_fs);
      if (check_en) begin
        chk("cyc_I",      sym_out_I,  m_i);
        chk("cyc_Q",      sym_out_Q,  m_q);
        chk("cyc_strobe", sym_strobe, m_stb);
        chk("cyc_uflow",  underflow,  m_uf);
        chk("cyc_busy",   busy,       m_run);
        chk("cyc_ready",  bit_ready,  (mq.size() < 2));
      end
    end
  end

  // Send one bit: called at negedge+1, returns at negedge+1 after the handshake edge.
  task automatic send_bit(input bit b);
    int t;
    bit_in = b;
    bit_valid = 1'b1;
    t = 0;
    while (!bit_ready && t < 50) begin
      @(negedge clk_fs); #1;
      t++;
    end
    if (t >= 50) chk("send_timeout", 8'd1, 8'd0);
    @(negedge clk_fs); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_fs); #1;
    end
  endtask

  logic [1:0] s3_i[3];
  logic [1:0] s3_q[3];
  int         s3_t[3];
  int         s3_n, s3_uf;

  initial begin : stim
    rst_n = 1'b0; en = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    idle_cycles(3);
    // Reset state
    chk("rst_I", sym_out_I, 8'h00);
    chk("rst_Q", sym_out_Q, 8'h00);
    chk("rst_strobe", sym_strobe, 8'h00);
    chk("rst_ready", bit_ready, 8'h01);
    chk("rst_busy", busy, 8'h00);
    rst_n = 1'b1;
    check_en = 1'b1;
    idle_cycles(2);

    // Single pair 0,1: strobe two cycles after the Q handshake, then underflow
    en = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    bit_valid = 1'b0;
    @(negedge clk_fs);
    chk("t2_I", sym_out_I, 8'h01);
    chk("t2_Q", sym_out_Q, 8'h03);
    chk("t2_strobe", sym_strobe, 8'h01);
    chk("t2_busy", busy, 8'h01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_fs);
      chk("t2_strobe_low", sym_strobe, 8'h00);
`ifdef QPSK_MAP_HOLD_EN
      chk("t2_hold_I", sym_out_I, 8'h01);
      chk("t2_hold_Q", sym_out_Q, 8'h03);
`else
      chk("t2_zero_I", sym_out_I, 8'h00);
      chk("t2_zero_Q", sym_out_Q, 8'h00);
`endif
    end
    @(negedge clk_fs);
    chk("t4_uflow", underflow, 8'h01);
    chk("t4_busy", busy, 8'h00);
    chk("t4_I", sym_out_I, 8'h00);
    @(negedge clk_fs);
    chk("t4_uflow_pulse", underflow, 8'h00);
    #1;
    idle_cycles(2);

    // Continuous stream 1,1,0,0,1,0
    s3_n = 0; s3_uf = 0;
    fork
      begin
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bit_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clk_fs);
          if (sym_strobe === 1'b1 && s3_n < 3) begin
            s3_i[s3_n] = sym_out_I; s3_q[s3_n] = sym_out_Q; s3_t[s3_n] = c;
            s3_n++;
          end
          if (underflow === 1'b1 && s3_n < 3) s3_uf++;
        end
      end
    join
    #1;
    chk("t3_nsym", s3_n, 8'd3);
    if (s3_n == 3) begin
      chk("t3_s0_I", s3_i[0], 8'h03); chk("t3_s0_Q", s3_q[0], 8'h03);
      chk("t3_s1_I", s3_i[1], 8'h01); chk("t3_s1_Q", s3_q[1], 8'h01);
      chk("t3_s2_I", s3_i[2], 8'h03); chk("t3_s2_Q", s3_q[2], 8'h01);
      chk("t3_gap1", s3_t[1] - s3_t[0], 8'd4);
      chk("t3_gap2", s3_t[2] - s3_t[1], 8'd4);
    end
    chk("t3_no_uflow", s3_uf, 8'd0);
    idle_cycles(4);

    // Reset mid-symbol drops a half-collected pair
    send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1);
    bit_valid = 1'b0;
    rst_n = 1'b0;
    idle_cycles(1);
    rst_n = 1'b1;
    idle_cycles(1);
    send_bit(1'b0); send_bit(1'b1);
    bit_valid = 1'b0;
    begin : wait_stb
      int t;
      t = 0;
      while (sym_strobe !== 1'b1 && t < 20) begin
        @(negedge clk_fs);
        t++;
      end
      chk("t5_strobe_seen", (t < 20), 8'd1);
      chk("t5_I", sym_out_I, 8'h01);
      chk("t5_Q", sym_out_Q, 8'h03);
    end
    #1;
    idle_cycles(8);

    // Randomized traffic against the model
    for (int blk = 0; blk < 12; blk++) begin
      int dens;
      dens = $urandom_range(1, 10);
      for (int c = 0; c < 250; c++) begin
        rst_n     = ($urandom_range(0, 499) != 0);
        en        = ($urandom_range(0, 9) != 0);
        bit_valid = ($urandom_range(1, 10) <= dens);
        bit_in    = $urandom_range(0, 1);
        @(negedge clk_fs); #1;
      end
    end
    rst_n = 1'b1; bit_valid = 1'b0; en = 1'b0;
    idle_cycles(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
